// File: rtl/uart_sample_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_sample_rx
// Brief    : 8N1 UART receiver that reassembles 3-byte frames into 22-bit
//            signed LED samples. Optional build macro: RX_TIMEOUT_EN enables
//            the inter-byte timeout that resyncs a stalled partial frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sample_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_serial,
    output logic [21:0] sample_out,
    output logic        sample_dv,
    output logic [7:0]  byte_out,
    output logic        byte_dv,
    output logic        frame_err,
    output logic        hdr_err,
    output logic        timeout_err,
    output logic        rx_active
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] c_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || TIMEOUT_BITS < 1) begin : g_bad_params
        $error("uart_sample_rx: CLKS_PER_BIT or TIMEOUT_BITS out of range");
    end

    logic        r_rx_meta;
    logic        r_rx_sync;
    state_t      r_state,     w_state_next;
    logic [15:0] r_cnt,       w_cnt_next;
    logic [2:0]  r_bit_idx,   w_bit_idx_next;
    logic [7:0]  r_shift,     w_shift_next;
    logic        r_wait_high, w_wait_high_next;
    logic        w_byte_done;
    logic        w_stop_low;
    logic        w_to_fire;

    logic [1:0]  r_idx;
    logic [5:0]  r_hi6;
    logic [7:0]  r_mid8;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_serial;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_wait_high <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_wait_high <= w_wait_high_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_wait_high_next = r_wait_high;
        w_byte_done      = 1'b0;
        w_stop_low       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // After a bad stop bit the line must return high before a new start counts.
                if (r_wait_high) begin
                    if (r_rx_sync) w_wait_high_next = 1'b0;
                end else if (!r_rx_sync) begin
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                end
            end
            S_START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_next     = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = r_rx_sync ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_next     = '0;
                    w_shift_next   = {r_rx_sync, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_next = S_STOP;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_next = '0;
                    if (r_rx_sync) begin
                        w_state_next = S_DONE;
                        w_byte_done  = 1'b1;
                    end else begin
                        w_state_next     = S_IDLE;
                        w_stop_low       = 1'b1;
                        w_wait_high_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign rx_active = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

`ifdef RX_TIMEOUT_EN
    localparam logic [31:0] c_TO_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    logic [31:0] r_to_cnt;
    logic        w_to_run;

    assign w_to_run  = (r_state == S_IDLE) && (r_idx != 2'd0);
    assign w_to_fire = w_to_run && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (!w_to_run || w_to_fire) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end
`else
    assign w_to_fire = 1'b0;
`endif

    // Frame assembler; strobes are registered so they land in the DONE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_hi6       <= '0;
            r_mid8      <= '0;
            sample_out  <= '0;
            sample_dv   <= 1'b0;
            byte_out    <= '0;
            byte_dv     <= 1'b0;
            frame_err   <= 1'b0;
            hdr_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            sample_dv   <= 1'b0;
            byte_dv     <= 1'b0;
            frame_err   <= w_stop_low;
            hdr_err     <= 1'b0;
            timeout_err <= w_to_fire;
            if (w_stop_low || w_to_fire) begin
                r_idx <= 2'd0;
            end else if (w_byte_done) begin
                byte_out <= r_shift;
                byte_dv  <= 1'b1;
                case (r_idx)
                    2'd0: begin
                        if (r_shift[7:6] != 2'b00) begin
                            hdr_err <= 1'b1;
                        end else begin
                            r_hi6 <= r_shift[5:0];
                            r_idx <= 2'd1;
                        end
                    end
                    2'd1: begin
                        r_mid8 <= r_shift;
                        r_idx  <= 2'd2;
                    end
                    default: begin
                        sample_out <= {r_hi6, r_mid8, r_shift};
                        sample_dv  <= 1'b1;
                        r_idx      <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_sample_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_sample_rx
// Brief    : Directed self-checking bench for uart_sample_rx (CLKS_PER_BIT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_sample_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_serial = 1'b1;
    logic [21:0] sample_out;
    logic        sample_dv;
    logic [7:0]  byte_out;
    logic        byte_dv;
    logic        frame_err;
    logic        hdr_err;
    logic        timeout_err;
    logic        rx_active;

    uart_sample_rx #(
        .CLKS_PER_BIT(8),
        .TIMEOUT_BITS(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_serial  (rx_serial),
        .sample_out (sample_out),
        .sample_dv  (sample_dv),
        .byte_out   (byte_out),
        .byte_dv    (byte_dv),
        .frame_err  (frame_err),
        .hdr_err    (hdr_err),
        .timeout_err(timeout_err),
        .rx_active  (rx_active)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe monitor, written only here.
    int          m_byte = 0, m_sample = 0, m_hdr = 0, m_frame = 0, m_to = 0;
    int          m_rise = 0, m_excl = 0;
    logic [21:0] m_last_sample = '0;
    logic [7:0]  m_last_byte = '0;
    logic        m_prev_act = 1'b0;

    always @(negedge clk) begin
        if (byte_dv) begin
            m_byte++;
            m_last_byte = byte_out;
        end
        if (sample_dv) begin
            m_sample++;
            m_last_sample = sample_out;
        end
        if (hdr_err) m_hdr++;
        if (frame_err) m_frame++;
        if (timeout_err) m_to++;
        if (rx_active && !m_prev_act) m_rise++;
        m_prev_act = rx_active;
        if ((int'(frame_err) + int'(hdr_err) + int'(timeout_err)) > 1 || (frame_err && sample_dv))
            m_excl++;
    end

    int s_byte = 0, s_sample = 0, s_hdr = 0, s_frame = 0, s_to = 0, s_rise = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_counts(input string tag, input int nb, input int ns,
                                 input int nh, input int nf, input int nt);
        check({tag, "_byte_dv"},     32'(m_byte - s_byte),     32'(nb));
        check({tag, "_sample_dv"},   32'(m_sample - s_sample), 32'(ns));
        check({tag, "_hdr_err"},     32'(m_hdr - s_hdr),       32'(nh));
        check({tag, "_frame_err"},   32'(m_frame - s_frame),   32'(nf));
        check({tag, "_timeout_err"}, 32'(m_to - s_to),         32'(nt));
        s_byte = m_byte; s_sample = m_sample; s_hdr = m_hdr;
        s_frame = m_frame; s_to = m_to;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sample_out"},  32'(sample_out),  32'h0);
        check({tag, "_byte_out"},    32'(byte_out),    32'h0);
        check({tag, "_strobes"},     32'({sample_dv, byte_dv, frame_err, hdr_err, timeout_err}), 32'h0);
        check({tag, "_rx_active"},   32'(rx_active),   32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_serial = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (8) @(negedge clk);
        end
        rx_serial = stop_bit;
        repeat (8) @(negedge clk);
        rx_serial = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Valid frame with bit 21 set
        send_byte(8'h2A, 1'b1);
        send_byte(8'hBC, 1'b1);
        send_byte(8'hDE, 1'b1);
        repeat (10) @(negedge clk);
        expect_counts("t1", 3, 1, 0, 0, 0);
        check("t1_sample", 32'(m_last_sample), 32'h2ABCDE);
        check("t1_negative", 32'($signed(m_last_sample) < 0), 32'h1);
        check("t1_byte_out", 32'(m_last_byte), 32'hDE);

        // Bad header byte is dropped
        send_byte(8'h40, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (10) @(negedge clk);
        expect_counts("t2", 4, 1, 1, 0, 0);
        check("t2_sample", 32'(m_last_sample), 32'h010203);

        // Framing error on second byte resets the assembler
        send_byte(8'h05, 1'b1);
        send_byte(8'h11, 1'b0);
        repeat (8) @(negedge clk);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (10) @(negedge clk);
        expect_counts("t3", 4, 1, 0, 1, 0);
        check("t3_sample", 32'(m_last_sample), 32'h001234);
        check("t3_sample_hold", 32'(sample_out), 32'h001234);

        // Two-clock glitch is a false start
        s_rise = m_rise;
        rx_serial = 1'b0;
        repeat (2) @(negedge clk);
        rx_serial = 1'b1;
        repeat (30) @(negedge clk);
        expect_counts("t4", 0, 0, 0, 0, 0);
        check("t4_active_pulses", 32'(m_rise - s_rise), 32'h1);

        // Reset in the middle of byte1 data bits
        send_byte(8'h3A, 1'b1);
        rx_serial = 1'b0;
        repeat (8) @(negedge clk);
        rx_serial = 1'b1;
        repeat (8) @(negedge clk);
        rx_serial = 1'b0;
        repeat (8) @(negedge clk);
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("t5_in_reset");
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h3F, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (10) @(negedge clk);
        expect_counts("t5", 4, 1, 0, 0, 0);
        check("t5_sample", 32'(m_last_sample), 32'h3FFFFF);

        // Long gap after byte0
        send_byte(8'h01, 1'b1);
        repeat (40) @(negedge clk);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        repeat (10) @(negedge clk);
`ifdef RX_TIMEOUT_EN
        expect_counts("t6", 4, 1, 0, 0, 1);
        check("t6_sample", 32'(m_last_sample), 32'h020304);
`else
        expect_counts("t6", 4, 1, 0, 0, 0);
        check("t6_sample", 32'(m_last_sample), 32'h010203);
`endif

        check("strobe_exclusive", 32'(m_excl), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
